// File: rtl/sdram_cache_pkg.sv
// Shared types and helpers for the 68000-to-SDRAM read cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e  - cache controller states
//   clog2_w  - ceiling log2 used to size the offset/index/tag fields
package sdram_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    WRITE  = 2'd3
  } state_e;

  function automatic int clog2_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Cache data store: single-port word RAM with per-byte write enables.
// Latency: asynchronous read, write takes effect at the rising edge.
// Backpressure: none; always accepts a write.
//
// Ports:
//   clk_i    - clock
//   addr_i   - word address {line index, word offset}
//   we_i     - byte write enables, [1] is the upper byte
//   wdata_i  - write data
//   rdata_o  - read data at addr_i (combinational)
module cache_data_ram #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sdram_cpu_cache.sv
// Direct-mapped read cache bridging the CPU toggle port to the SDRAM CPU channel.
// Latency: hit acks 2 cycles after the request toggle; misses and writes wait on SDRAM.
// Backpressure: one request in flight; CPU waits on cpu_ack, SDRAM holds off via ram_ack.
//
// Ports:
//   clk, reset                      - clock, async active-high reset
//   cpu_addr/data/be/rw/req, cpu_ack, cpu_q
//                                   - CPU side, toggle handshake (req != ack => pending)
//   flush                           - one-cycle pulse, invalidates every line
//   ram_addr/data/be/we/req         - SDRAM command, req held until ram_ack
//   ram_ack, ram_valid, ram_q       - SDRAM accept/done pulse and fill data strobe
module sdram_cpu_cache
  import sdram_cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  input  logic        flush,
  output logic [25:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [1:0]  ram_be,
  output logic        ram_we,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic        ram_valid,
  input  logic [15:0] ram_q
);

  localparam int OFF_W = clog2_w(LINE_WORDS);
  localparam int IDX_W = clog2_w(LINES);
  localparam int TAG_W = 26 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] K_LAST = OFF_W'(LINE_WORDS - 1);

  state_e             state_q;
  logic [25:0]        addr_q;
  logic [15:0]        data_q;
  logic [1:0]         be_q;
  logic               rw_q;
  logic [OFF_W-1:0]   k_q;
  logic               flushed_q;
  logic               cpu_ack_q;
  logic [15:0]        cpu_q_q;
  logic               ram_req_q;
  logic               ram_we_q;
  logic [25:0]        ram_addr_q;
  logic [15:0]        ram_data_q;
  logic [1:0]         ram_be_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];

  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   fill_done;
  logic [OFF_W+IDX_W-1:0] dram_addr;
  logic [1:0]             dram_we;
  logic [15:0]            dram_wdat;
  logic [15:0]            dram_rdat;

  assign off = addr_q[OFF_W-1:0];
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[25 -: TAG_W];

  // A flush landing on the lookup cycle wins: the lookup sees an empty cache.
  assign hit       = valid_q[idx] && (tag_q[idx] == tag) && !flush;
  assign fill_done = (state_q == FILL) && ram_valid && (k_q == K_LAST);

  // Data RAM port: fill words go to the counter slot, everything else
  // addresses the requested word (read for hits, byte merge for write hits).
  always_comb begin
    dram_addr = {idx, off};
    dram_we   = 2'b00;
    dram_wdat = data_q;
    if (state_q == FILL) begin
      dram_addr = {idx, k_q};
      dram_wdat = ram_q;
      if (ram_valid) dram_we = 2'b11;
    end else if (state_q == LOOKUP && !rw_q && hit) begin
      dram_we = be_q;
    end
  end

  cache_data_ram #(
    .AW (OFF_W + IDX_W)
  ) u_data_ram (
    .clk_i   (clk),
    .addr_i  (dram_addr),
    .we_i    (dram_we),
    .wdata_i (dram_wdat),
    .rdata_o (dram_rdat)
  );

  // Tags are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[idx] <= tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      rw_q       <= 1'b1;
      k_q        <= '0;
      flushed_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_q_q    <= '0;
      ram_req_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_be_q   <= '0;
      valid_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req != cpu_ack_q) begin
            addr_q  <= cpu_addr;
            data_q  <= cpu_data;
            be_q    <= cpu_be;
            rw_q    <= cpu_rw;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rw_q) begin
            if (hit) begin
              cpu_q_q   <= dram_rdat;
              cpu_ack_q <= ~cpu_ack_q;
              state_q   <= IDLE;
            end else begin
              ram_addr_q   <= {addr_q[25:OFF_W], {OFF_W{1'b0}}};
              ram_we_q     <= 1'b0;
              ram_be_q     <= 2'b11;
              ram_req_q    <= 1'b1;
              valid_q[idx] <= 1'b0;
              k_q          <= '0;
              flushed_q    <= 1'b0;
              state_q      <= FILL;
            end
          end else begin
            // Write-through, no allocate; the cache word was merged above on a hit.
            ram_addr_q <= addr_q;
            ram_data_q <= data_q;
            ram_be_q   <= be_q;
            ram_we_q   <= 1'b1;
            ram_req_q  <= 1'b1;
            state_q    <= WRITE;
          end
        end
        FILL: begin
          if (ram_ack) ram_req_q <= 1'b0;
          if (flush) flushed_q <= 1'b1;
          if (ram_valid) begin
            k_q <= k_q + 1'b1;
            if (k_q == off) cpu_q_q <= ram_q;
            if (k_q == K_LAST) begin
              // A flush seen during the fill leaves the line invalid.
              if (!flushed_q) valid_q[idx] <= 1'b1;
              cpu_ack_q <= ~cpu_ack_q;
              state_q   <= IDLE;
            end
          end
        end
        WRITE: begin
          if (ram_ack) begin
            ram_req_q <= 1'b0;
            cpu_ack_q <= ~cpu_ack_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Last assignment wins, so a flush also overrides a fill completing this edge.
      if (flush) valid_q <= '0;
    end
  end

  assign cpu_ack  = cpu_ack_q;
  assign cpu_q    = cpu_q_q;
  assign ram_req  = ram_req_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_be   = ram_be_q;

endmodule

// File: tb/tb_sdram_cpu_cache.sv
// Testbench for sdram_cpu_cache: directed scenarios then randomized traffic,
// checked against a memory model plus a line-level cache occupancy model.
// Latency/backpressure: bench plays both the CPU and the SDRAM controller.
module tb_sdram_cpu_cache;

  localparam int LW    = 4;
  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] cpu_addr;
  logic [15:0] cpu_data;
  logic [1:0]  cpu_be;
  logic        cpu_rw;
  logic        cpu_req;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic        flush;
  logic [25:0] ram_addr;
  logic [15:0] ram_data;
  logic [1:0]  ram_be;
  logic        ram_we;
  logic        ram_req;
  logic        ram_ack;
  logic        ram_valid;
  logic [15:0] ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [int];
  bit          v_m [LINES];
  int          t_m [LINES];

  sdram_cpu_cache #(.LINE_WORDS(LW), .LINES(LINES)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_be    (cpu_be),
    .cpu_rw    (cpu_rw),
    .cpu_req   (cpu_req),
    .cpu_ack   (cpu_ack),
    .cpu_q     (cpu_q),
    .flush     (flush),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_be    (ram_be),
    .ram_we    (ram_we),
    .ram_req   (ram_req),
    .ram_ack   (ram_ack),
    .ram_valid (ram_valid),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'((a * 40503) ^ (a >>> 5));
  endfunction

  function automatic int idx_of(input int a);
    return (a / LW) % LINES;
  endfunction

  function automatic int tag_of(input int a);
    return a / (LW * LINES);
  endfunction

  function automatic bit model_hit(input int a);
    return v_m[idx_of(a)] && (t_m[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) v_m[i] = 1'b0;
  endtask

  // flush_lk: pulse flush on the lookup cycle; flush_at: pulse flush with
  // that fill strobe (0-based); rst_at: assert reset after that many strobes.
  task automatic do_read(input int a, input bit flush_lk, input int flush_at, input int rst_at);
    int base;
    int w;
    int cyc;
    int ack_cyc;
    int next_s;
    bit hit;
    bit strobe;
    logic [15:0] exp;
    base = a - (a % LW);
    if (flush_lk) model_clear();
    hit = model_hit(a);
    exp = mem_rd(a);
    cpu_addr = 26'(a);
    cpu_rw   = 1'b1;
    cpu_data = 16'($urandom);
    cpu_be   = 2'($urandom);
    cpu_req  = !cpu_req;
    @(posedge clk); #1;
    check_eq("rd_busy", 32'(cpu_ack), 32'(!cpu_req));
    check_eq("rd_noreq_latch", 32'(ram_req), 0);
    if (flush_lk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (hit) begin
      check_eq("hit_ack", 32'(cpu_ack), 32'(cpu_req));
      check_eq("hit_q", 32'(cpu_q), 32'(exp));
      check_eq("hit_no_ram_req", 32'(ram_req), 0);
    end else begin
      check_eq("miss_ram_req", 32'(ram_req), 1);
      check_eq("miss_ram_addr", 32'(ram_addr), 32'(base));
      check_eq("miss_ram_we", 32'(ram_we), 0);
      check_eq("miss_ram_be", 32'(ram_be), 3);
      check_eq("miss_no_ack", 32'(cpu_ack), 32'(!cpu_req));
      ack_cyc = $urandom_range(0, 2);
      next_s  = ack_cyc + $urandom_range(0, 1);
      w = 0;
      cyc = 0;
      while (w < LW && cyc < 100) begin
        strobe    = (cyc == next_s);
        ram_ack   = (cyc == ack_cyc);
        ram_valid = strobe;
        ram_q     = strobe ? mem_rd(base + w) : 16'($urandom);
        flush     = strobe && (w == flush_at);
        @(posedge clk); #1;
        ram_ack   = 1'b0;
        ram_valid = 1'b0;
        flush     = 1'b0;
        if (cyc < ack_cyc) check_eq("fill_req_hold", 32'(ram_req), 1);
        if (cyc == ack_cyc) check_eq("fill_req_drop", 32'(ram_req), 0);
        if (strobe) begin
          w++;
          if (w == LW) begin
            check_eq("fill_ack", 32'(cpu_ack), 32'(cpu_req));
            check_eq("fill_q", 32'(cpu_q), 32'(exp));
          end else begin
            check_eq("fill_ack_early", 32'(cpu_ack), 32'(!cpu_req));
          end
          if (w == rst_at) begin
            reset   = 1'b1;
            cpu_req = 1'b0;
            #1;
            check_eq("rst_ram_req", 32'(ram_req), 0);
            check_eq("rst_cpu_ack", 32'(cpu_ack), 0);
            check_eq("rst_cpu_q", 32'(cpu_q), 0);
            model_clear();
            @(posedge clk); #1;
            reset = 1'b0;
            return;
          end
          next_s = cyc + 1 + $urandom_range(0, 2);
        end
        cyc++;
      end
      if (w < LW) check_eq("fill_timeout", w, LW);
      v_m[idx_of(a)] = 1'b0;
      if (flush_at >= 0 && flush_at < LW) begin
        model_clear();
      end else begin
        v_m[idx_of(a)] = 1'b1;
        t_m[idx_of(a)] = tag_of(a);
      end
    end
  endtask

  task automatic do_write(input int a, input logic [15:0] d, input logic [1:0] be);
    int n;
    logic [15:0] nv;
    cpu_addr = 26'(a);
    cpu_data = d;
    cpu_be   = be;
    cpu_rw   = 1'b0;
    cpu_req  = !cpu_req;
    @(posedge clk); #1;
    check_eq("wr_busy", 32'(cpu_ack), 32'(!cpu_req));
    @(posedge clk); #1;
    check_eq("wr_ram_req", 32'(ram_req), 1);
    check_eq("wr_ram_we", 32'(ram_we), 1);
    check_eq("wr_ram_addr", 32'(ram_addr), 32'(a));
    check_eq("wr_ram_data", 32'(ram_data), 32'(d));
    check_eq("wr_ram_be", 32'(ram_be), 32'(be));
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq("wr_req_hold", 32'(ram_req), 1);
      check_eq("wr_ack_early", 32'(cpu_ack), 32'(!cpu_req));
    end
    ram_ack = 1'b1;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    check_eq("wr_ack", 32'(cpu_ack), 32'(cpu_req));
    check_eq("wr_req_drop", 32'(ram_req), 0);
    nv = mem_rd(a);
    if (be[1]) nv[15:8] = d[15:8];
    if (be[0]) nv[7:0]  = d[7:0];
    mem[a] = nv;
  endtask

  initial begin
    int a;
    int r;
    int fa;
    bit fl;
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_data  = '0;
    cpu_be    = '0;
    cpu_rw    = 1'b1;
    cpu_req   = 1'b0;
    flush     = 1'b0;
    ram_ack   = 1'b0;
    ram_valid = 1'b0;
    ram_q     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_ack0", 32'(cpu_ack), 0);
    check_eq("rst_cpu_q0", 32'(cpu_q), 0);
    check_eq("rst_ram_req0", 32'(ram_req), 0);
    check_eq("rst_ram_we0", 32'(ram_we), 0);
    check_eq("rst_ram_addr0", 32'(ram_addr), 0);
    check_eq("rst_ram_data0", 32'(ram_data), 0);
    check_eq("rst_ram_be0", 32'(ram_be), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then hit in the same line.
    mem['h100] = 16'hABCD;
    mem['h101] = 16'hABCD;
    do_read('h100, 1'b0, -1, -1);
    check_eq("cold_q", 32'(cpu_q), 32'h0000ABCD);
    do_read('h102, 1'b0, -1, -1);

    // Write hit merges the upper byte into the cached word.
    do_read('h101, 1'b0, -1, -1);
    do_write('h101, 16'h1234, 2'b10);
    do_read('h101, 1'b0, -1, -1);
    check_eq("wr_merge_q", 32'(cpu_q), 32'h000012CD);

    // Aliasing lines evict each other.
    do_read('h100 + LINES * LW, 1'b0, -1, -1);
    do_read('h100, 1'b0, -1, -1);

    // Flush on the third fill strobe, then re-read misses.
    do_read('h200, 1'b0, 2, -1);
    do_read('h200, 1'b0, -1, -1);

    // Flush on the lookup cycle forces a miss on a resident line.
    do_read('h201, 1'b1, -1, -1);

    // Reset mid-fill after two strobes; the line must miss afterwards.
    do_read('h300, 1'b0, -1, 2);
    do_read('h301, 1'b0, -1, -1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      a = 'h2000 + $urandom_range(0, 2) * LW * LINES + $urandom_range(0, 7) * LW
          + $urandom_range(0, LW - 1);
      if (r < 65) begin
        fa = ($urandom_range(0, 9) == 0) ? $urandom_range(0, LW - 1) : -1;
        fl = ($urandom_range(0, 19) == 0);
        do_read(a, fl, fa, -1);
      end else if (r < 90) begin
        do_write(a, 16'($urandom), 2'($urandom));
      end else begin
        // Stray SDRAM strobes while idle must be ignored.
        fl        = 1'($urandom_range(0, 1));
        ram_ack   = 1'b1;
        ram_valid = 1'b1;
        ram_q     = 16'($urandom);
        flush     = fl;
        @(posedge clk); #1;
        ram_ack   = 1'b0;
        ram_valid = 1'b0;
        flush     = 1'b0;
        if (fl) model_clear();
        check_eq("idle_stray_ack", 32'(cpu_ack), 32'(cpu_req));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_cache.md
# sdram_cpu_cache

Read cache and request bridge between the 68000 CPU SDRAM port (toggle request/acknowledge) and the SDRAM controller CPU channel. Read misses fetch whole lines by burst; writes go straight through to SDRAM and update the cache on a hit. Hits complete without touching SDRAM, which shortens DTACK for ROM and work-RAM fetches.

## Interface
- `LINE_WORDS`, default 4: 16-bit words per line; power of two, 2..8.
- `LINES`, default 64: number of lines; power of two; direct-mapped.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_addr` in 26: word address [26:1].
- `cpu_data` in 16: write data.
- `cpu_be` in 2: byte enables; [1] is upper byte.
- `cpu_rw` in 1: 1 is read, 0 is write.
- `cpu_req` in 1: toggle; a request is pending while `cpu_req != cpu_ack`.
- `cpu_ack` out 1: toggle; made equal to `cpu_req` on completion.
- `cpu_q` out 16: read data; valid when `cpu_ack` toggles, held until the next read completes.
- `flush` in 1: one-cycle pulse; invalidates all lines.
- `ram_addr` out 26: word address. Line-aligned for fills, exact for writes.
- `ram_data` out 16: write data.
- `ram_be` out 2: byte enables. Always 2'b11 for fills.
- `ram_we` out 1: 1 is write, 0 is burst read of `LINE_WORDS` words.
- `ram_req` out 1: level; held high until `ram_ack` is seen.
- `ram_ack` in 1: one-cycle pulse.
  - For a write: the write is done.
  - For a read: the command is accepted.
- `ram_valid` in 1: one-cycle strobe per returned fill word. Words return in order from the line base. A strobe may arrive in the same cycle as `ram_ack` or later.
- `ram_q` in 16: fill data, qualified by `ram_valid`.

## Operation
- Address split:
  - offset = `cpu_addr[log2(LINE_WORDS):1]`
  - index = the next log2(LINES) bits
  - tag = the remaining upper bits
- Per-line state: valid bit and tag, held in registers. Data is held in the data RAM.
- State machine:
  - IDLE: when `cpu_req != cpu_ack`, latch addr, data, be and rw, then go to LOOKUP.
  - LOOKUP, 1 cycle: compare the tag and check the valid bit.
    - Read hit: `cpu_q` = cached word; toggle `cpu_ack`; go to IDLE.
    - Read miss: drive the line-aligned `ram_addr`, `ram_we`=0, `ram_req`=1; clear the line's valid bit; go to FILL.
    - Write, hit or miss: `ram_req`=1, `ram_we`=1, `ram_data`/`ram_be` = latched values; go to WRITE.
    - Write hit only: also merge the enabled bytes into the cached word in this cycle.
  - FILL:
    - Drop `ram_req` in the cycle after `ram_ack`.
    - Each `ram_valid` stores `ram_q` at word counter k, then k increments. k wraps at `LINE_WORDS`.
    - When k equals the requested offset, also capture the word into `cpu_q`.
    - After the last strobe: write the tag, set valid, toggle `cpu_ack`, go to IDLE.
  - WRITE: on `ram_ack`, drop `ram_req`, toggle `cpu_ack`, go to IDLE.
- Write misses do not allocate a line.
- `flush`:
  - Clears all valid bits in the same edge.
  - If it arrives during FILL, the fill still completes and answers the CPU, but the line is not marked valid.
  - If it arrives in the same cycle as a LOOKUP, the lookup is treated as a miss.
- A change of `cpu_req` while busy is ignored until the current request completes. The CPU protocol never does this.
- `ram_valid` or `ram_ack` outside FILL/WRITE is ignored.

## Timing
- Reset values: `cpu_ack`=0, `cpu_q`=0, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `ram_be`=0, all valid bits 0, state IDLE.
- Reset mid-FILL or mid-WRITE aborts immediately. The SDRAM controller is reset together with this block.
- Hit:
  - `cpu_req` toggles before edge N, so IDLE latches at N.
  - LOOKUP occupies edge N+1.
  - `cpu_ack` and `cpu_q` update at edge N+1 and are visible in cycle N+1..N+2.
  - Total: 2 cycles from the request toggle.
- Miss: `ram_req` rises at edge N+1; `cpu_ack` toggles at the edge that samples the last `ram_valid`.
- Write: `ram_req` rises at edge N+1; `cpu_ack` toggles at the edge that samples `ram_ack`.
- Back-to-back: a new toggle observed in IDLE is latched in the same cycle, with no idle bubble beyond the IDLE state.

## Structure
- Package `sdram_cache_pkg`:
  - state enum: IDLE, LOOKUP, FILL, WRITE
  - function `clog2_w` for the field widths
- Sub-module `cache_data_ram`: single-port LINES×LINE_WORDS×16 with per-byte write enables and asynchronous read. It follows the codebase's unregistered single-port RAM style.
- Tag/valid array and FSM live in the top module.

## Test plan
- Cold read 0x000100, memory model word = 0xABCD:
  - `ram_req` with `ram_addr`=0x000100; 4 strobes returned.
  - `cpu_q`=0xABCD; `ack` toggles after the 4th strobe.
- Re-read 0x000102 after that fill → `cpu_ack` toggles 2 cycles after `req`, no `ram_req`, `cpu_q` = model word.
- Write 0x1234 with be=2'b10 to a cached 0x000101 holding 0xABCD → `ram_we`=1, `ram_be`=2'b10; a re-read hits with 0x12CD.
- Aliasing:
  - Read A, then read A + LINES×LINE_WORDS → second access misses and refills.
  - Re-read A → misses again.
- `flush` pulsed during the third `ram_valid` of a fill:
  - CPU still gets the correct word.
  - Immediate re-read of the same address → miss.
- Assert `reset` while in FILL after 2 strobes → `ram_req`=0 and `cpu_ack`=0 immediately; a next read to the same line misses.
